uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares a single UART transmitter among `N_REQ` byte requesters. It accepts one byte at a time from the winning requester and issues a one-cycle start strobe to the transmitter. It holds the byte stable until the transmitter reports frame completion, and recovers from a stuck transmitter with a timeout. It sits between the on-chip byte producers and the TX UART, in the same `clk` domain as the RX/TX datapath.

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and TX-UART-side signals of the UART transmit arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic's view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 8
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ*DATA_BITS-1:0] req_data_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic                       tx_start_o;
  logic [DATA_BITS-1:0]       tx_data_o;
  logic                       tx_done_i;
  logic [GW-1:0]              grant_id_o;
  logic                       busy_o;
  logic                       timeout_o;

  modport master (
    input  req_valid_i, req_data_i, tx_done_i,
    output req_ready_o, tx_start_o, tx_data_o, grant_id_o, busy_o, timeout_o
  );

  modport slave (
    output req_valid_i, req_data_i, tx_done_i,
    input  req_ready_o, tx_start_o, tx_data_o, grant_id_o, busy_o, timeout_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one TX UART among N_REQ byte producers, with a
// one-cycle start strobe, held byte, and a timeout for a transmitter that never finishes.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GRANT_INIT = GW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        last_q, last_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [DATA_BITS-1:0] req_bytes [N_REQ];
  logic [GW-1:0]        winner;
  logic [GW-1:0]        scan_idx;
  logic [GW:0]          scan_sum;
  logic                 found;
  logic [N_REQ-1:0]     ready_oh;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      req_bytes[k] = bus.req_data_i[k*DATA_BITS +: DATA_BITS];
    end
  end

  // Search starts just after the last grant and wraps, so the first hit is the fair winner.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      scan_sum = {1'b0, last_q} + (GW+1)'(i);
      if (scan_sum >= (GW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (GW+1)'(N_REQ);
      end
      scan_idx = scan_sum[GW-1:0];
      if (!found && bus.req_valid_i[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ready_oh = '0;
    if (state_q == IDLE && found) begin
      ready_oh[winner] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          data_d  = req_bytes[winner];
          grant_d = winner;
          last_d  = winner;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (bus.tx_done_i || cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_INIT;
      grant_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A done pulse in the final WAIT cycle takes priority, and a reset aborts silently.
  assign bus.timeout_o   = (state_q == WAIT) && (cnt_q == CNT_LAST) && !bus.tx_done_i && !rst;
  assign bus.req_ready_o = ready_oh;
  assign bus.tx_start_o  = (state_q == START);
  assign bus.tx_data_o   = data_q;
  assign bus.grant_id_o  = grant_q;
  assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, corner-case sequences, and
// randomized traffic checked cycle by cycle against a transfer-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DB = 8;
  localparam int T  = 24;

  logic clk = 1'b0;
  logic rst;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_BITS(DB)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DB), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: a transfer is active from acceptance+1 until it ends; its
  // strobe cycle timestamp gives start, timeout and completion by plain arithmetic.
  bit          m_on     = 1'b0;
  bit          m_act    = 1'b0;
  int          m_strobe = 0;
  int          m_last   = N - 1;
  int          m_grant  = 0;
  logic [DB-1:0] m_data = '0;

  logic [N-1:0]  s_ready;
  logic          s_start;
  logic [DB-1:0] s_data;
  logic [1:0]    s_grant;
  logic          s_busy;
  logic          s_to;

  typedef struct {
    string         nm;
    int            n;
    logic          r;
    logic [N-1:0]  v;
    logic [N*DB-1:0] d;
    logic          dn;
    logic [N-1:0]  e_ready;
    logic          e_start;
    logic [DB-1:0] e_data;
    logic [1:0]    e_grant;
    logic          e_busy;
    logic          e_to;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return -1;
  endfunction

  task automatic step(input logic r, input logic [N-1:0] v, input logic [N*DB-1:0] d,
                      input logic dn);
    int w;
    int age;
    logic [N-1:0] e_ready;
    logic e_start, e_to;
    rst             = r;
    bus.req_valid_i = v;
    bus.req_data_i  = d;
    bus.tx_done_i   = dn;
    #4;
    s_ready = bus.req_ready_o;
    s_start = bus.tx_start_o;
    s_data  = bus.tx_data_o;
    s_grant = bus.grant_id_o;
    s_busy  = bus.busy_o;
    s_to    = bus.timeout_o;
    w   = rr_pick(m_last, v);
    age = cyc - m_strobe;
    if (m_on) begin
      e_ready = '0;
      if (!m_act && w >= 0) e_ready[w] = 1'b1;
      e_start = m_act && age == 0;
      e_to    = m_act && age == T && !dn && !r;
      chk("model", {s_ready, s_start, s_data, s_grant, s_busy, s_to},
          {e_ready, e_start, m_data, 2'(m_grant), m_act, e_to});
    end
    if (r) begin
      m_act = 1'b0; m_last = N - 1; m_grant = 0; m_data = '0; m_on = 1'b1;
    end else if (!m_act) begin
      if (w >= 0) begin
        m_act = 1'b1; m_strobe = cyc + 1; m_last = w; m_grant = w;
        m_data = d[w*DB +: DB];
      end
    end else if (age > 0 && (dn || age == T)) begin
      m_act = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    logic [N*DB-1:0] d_all;
    int starts, to_cnt, to_at;
    logic [N-1:0] bad_ready;

    rst = 1'b1; bus.req_valid_i = '0; bus.req_data_i = '0; bus.tx_done_i = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, '0, '0, 1'b0);

    tbl.push_back('{"reset",    1, 1'b1, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{"accept2",  1, 1'b0, 4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0});
    tbl.push_back('{"strobe2",  1, 1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b1, 8'hA5, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{"wait2",   19, 1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{"done2",    1, 1'b0, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b1, 1'b0});
    tbl.push_back('{"idle2",    1, 1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{"spurdone", 2, 1'b0, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{"accept0",  1, 1'b0, 4'b0001, 32'h0000_003C, 1'b0, 4'b0001, 1'b0, 8'hA5, 2'd2, 1'b0, 1'b0});
    tbl.push_back('{"strobe0",  1, 1'b0, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{"done0",    1, 1'b0, 4'b0000, 32'h0,         1'b1, 4'b0000, 1'b0, 8'h3C, 2'd0, 1'b1, 1'b0});
    tbl.push_back('{"idle0",    1, 1'b0, 4'b0000, 32'h0,         1'b0, 4'b0000, 1'b0, 8'h3C, 2'd0, 1'b0, 1'b0});

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].dn);
        chk(tbl[i].nm, {s_ready, s_start, s_data, s_grant, s_busy, s_to},
            {tbl[i].e_ready, tbl[i].e_start, tbl[i].e_data, tbl[i].e_grant,
             tbl[i].e_busy, tbl[i].e_to});
      end
    end

    // Fairness: all requesters always valid, done 10 cycles after each strobe.
    step(1'b1, '0, '0, 1'b0);
    d_all  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    starts = 0;
    for (int g = 0; g < 6; g++) begin
      step(1'b0, 4'hF, d_all, 1'b0);
      chk("fair_ready", s_ready, 32'(1) << (g % N));
      step(1'b0, 4'hF, d_all, 1'b0);
      starts += int'(s_start);
      chk("fair_strobe", {s_start, s_grant, s_data},
          {1'b1, 2'(g % N), 8'(8'hA0 + 8'h11 * (g % N))});
      for (int k = 1; k <= 10; k++) begin
        step(1'b0, 4'hF, d_all, k == 10);
        starts += int'(s_start);
      end
    end
    chk("fair_starts", starts, 6);

    // Timeout with no done; requester 1 stays valid and is re-accepted right after.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0010, 32'h0000_5A00, 1'b0);
    chk("to_accept", s_ready, 4'b0010);
    to_cnt = 0; to_at = -1;
    for (int k = 0; k <= T; k++) begin
      step(1'b0, 4'b0010, 32'h0000_5A00, 1'b0);
      if (k == 0) chk("to_strobe", s_start, 1'b1);
      if (s_to) begin to_cnt++; to_at = k; end
    end
    chk("to_count", to_cnt, 1);
    chk("to_age", to_at, T);
    step(1'b0, 4'b0010, 32'h0000_5A00, 1'b0);
    chk("to_reaccept", {s_busy, s_ready}, {1'b0, 4'b0010});

    // Done arrives in the same cycle the timeout would fire.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0001, 32'h0000_0077, 1'b0);
    to_cnt = 0;
    for (int k = 0; k <= T; k++) begin
      step(1'b0, 4'b0000, 32'h0, k == T);
      to_cnt += int'(s_to);
      if (k == T) chk("collide_busy", s_busy, 1'b1);
    end
    chk("collide_noto", to_cnt, 0);
    step(1'b0, 4'b0000, 32'h0, 1'b0);
    chk("collide_idle", s_busy, 1'b0);

    // Reset five cycles after the strobe, then a late done.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b1000, 32'hE100_0000, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0);
    chk("rstw_strobe", {s_start, s_grant, s_data}, {1'b1, 2'd3, 8'hE1});
    for (int k = 1; k <= 4; k++) step(1'b0, 4'b0000, 32'h0, 1'b0);
    step(1'b1, 4'b0000, 32'h0, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b1);
    chk("rstw_outputs", {s_ready, s_start, s_data, s_grant, s_busy, s_to}, 17'h0);
    step(1'b0, 4'b1001, 32'h4400_0011, 1'b0);
    chk("rstw_next", s_ready, 4'b0001);
    step(1'b0, 4'b0000, 32'h0, 1'b0);
    chk("rstw_grant", {s_start, s_grant, s_data}, {1'b1, 2'd0, 8'h11});

    // Requester 1 pulses valid only while the arbiter is busy.
    step(1'b1, '0, '0, 1'b0);
    step(1'b0, 4'b0100, 32'h0099_0000, 1'b0);
    step(1'b0, 4'b0000, 32'h0, 1'b0);
    bad_ready = '0; starts = 0;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, (k >= 2 && k <= 4) ? 4'b0010 : 4'b0000, 32'h0000_3300, k == 8);
      bad_ready |= s_ready;
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 4'b0000, 32'h0, 1'b0);
      bad_ready |= s_ready;
      starts += int'(s_start);
    end
    chk("drop_ready", bad_ready, 4'b0000);
    chk("drop_starts", starts, 0);
    chk("drop_grant", {s_busy, s_grant}, {1'b0, 2'd2});

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] v;
      v = ($urandom_range(0, 9) < 3) ? 4'b0000 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 299) == 0, v, $urandom(), $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
